// File: rtl/resize_capture.sv
// resize_capture: stream sink for the resize filter output. Captures one frame
// of pixels in raster order into an internal memory, checks the pixel count
// against the expected frame size, keeps a checksum and offers a registered
// random-access read port.
module resize_capture #(
    parameter int unsigned SRC_W       = 410,
    parameter int unsigned SRC_H       = 361,
    parameter int unsigned RESIZE_SIZE = 3,
    parameter int unsigned ADDR_W      = 17
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              scale,
    input  logic              pix_valid,
    input  logic [7:0]        pix_data,
    input  logic              pix_last,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_data,
    output logic              busy,
    output logic              done,
    output logic              len_err,
    output logic              overrun,
    output logic [20:0]       pix_count,
    output logic [23:0]       checksum
);

    localparam int unsigned MAX_PIX  = 1 << ADDR_W;
    localparam int unsigned UP_W     = SRC_W * RESIZE_SIZE;
    localparam int unsigned UP_H     = SRC_H * RESIZE_SIZE;
    localparam int unsigned DN_W     = (SRC_W + RESIZE_SIZE - 1) / RESIZE_SIZE;
    localparam int unsigned DN_H     = (SRC_H + RESIZE_SIZE - 1) / RESIZE_SIZE;
    localparam int unsigned EXP_N_UP = UP_W * UP_H;
    localparam int unsigned EXP_N_DN = DN_W * DN_H;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CAPT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        scale_q, scale_d;
    logic [20:0] wr_addr_q, wr_addr_d;
    logic [20:0] count_q, count_d;
    logic [23:0] csum_q, csum_d;
    logic        len_err_q, len_err_d;
    logic        overrun_q, overrun_d;
    logic [7:0]  rd_data_q;
    logic        we;
    logic        in_range;
    logic [31:0] exp_n;
    logic [7:0]  mem_q [MAX_PIX];

    // Expected pixel count follows the direction latched at start.
    assign exp_n    = scale_q ? 32'(EXP_N_UP) : 32'(EXP_N_DN);
    assign in_range = (32'(wr_addr_q) < 32'(MAX_PIX));

    // Control and status registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            scale_q   <= 1'b0;
            wr_addr_q <= '0;
            count_q   <= '0;
            csum_q    <= '0;
            len_err_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            scale_q   <= scale_d;
            wr_addr_q <= wr_addr_d;
            count_q   <= count_d;
            csum_q    <= csum_d;
            len_err_q <= len_err_d;
            overrun_q <= overrun_d;
        end
    end

    // Next-state logic: start (in any state) wins over a same-cycle pixel.
    always_comb begin
        state_d   = state_q;
        scale_d   = scale_q;
        wr_addr_d = wr_addr_q;
        count_d   = count_q;
        csum_d    = csum_q;
        len_err_d = len_err_q;
        overrun_d = overrun_q;
        we        = 1'b0;
        if (start) begin
            state_d   = CAPT;
            scale_d   = scale;
            wr_addr_d = '0;
            count_d   = '0;
            csum_d    = '0;
            len_err_d = 1'b0;
            overrun_d = 1'b0;
        end else if (state_q == CAPT && pix_valid) begin
            we        = in_range;
            wr_addr_d = wr_addr_q + 21'd1;
            csum_d    = csum_q + {16'b0, pix_data};
            count_d   = (count_q == '1) ? count_q : count_q + 21'd1;
            if (32'(wr_addr_q) >= exp_n || !in_range) begin
                overrun_d = 1'b1;
            end
            if (pix_last) begin
                state_d   = DONE;
                len_err_d = (32'(count_d) != exp_n);
            end
        end
    end

    // Frame memory write port (not reset).
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[wr_addr_q[ADDR_W-1:0]] <= pix_data;
        end
    end

    // Registered read port; a same-cycle write is seen on the following read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= mem_q[rd_addr];
        end
    end

    assign rd_data   = rd_data_q;
    assign busy      = (state_q == CAPT);
    assign done      = (state_q == DONE);
    assign len_err   = len_err_q;
    assign overrun   = overrun_q;
    assign pix_count = count_q;
    assign checksum  = csum_q;

endmodule

// File: tb/tb_resize_capture.sv
// Directed testbench for resize_capture using a 4x4 source with factor 3.
// A second instance with a 4-entry memory shares all stimulus except rd_addr.
module tb_resize_capture;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        scale;
    logic        pix_valid;
    logic [7:0]  pix_data;
    logic        pix_last;
    logic [7:0]  rd_addr;
    logic [7:0]  rd_data;
    logic        busy, done, len_err, overrun;
    logic [20:0] pix_count;
    logic [23:0] checksum;

    logic [1:0]  c_rd_addr;
    logic [7:0]  c_rd_data;
    logic        c_busy, c_done, c_len_err, c_overrun;
    logic [20:0] c_pix_count;
    logic [23:0] c_checksum;

    int tests_run;
    int tests_failed;

    resize_capture #(.SRC_W(4), .SRC_H(4), .RESIZE_SIZE(3), .ADDR_W(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .scale(scale),
        .pix_valid(pix_valid), .pix_data(pix_data), .pix_last(pix_last),
        .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy), .done(done),
        .len_err(len_err), .overrun(overrun), .pix_count(pix_count),
        .checksum(checksum)
    );

    resize_capture #(.SRC_W(4), .SRC_H(4), .RESIZE_SIZE(3), .ADDR_W(2)) u_cap (
        .clk(clk), .rst_n(rst_n), .start(start), .scale(scale),
        .pix_valid(pix_valid), .pix_data(pix_data), .pix_last(pix_last),
        .rd_addr(c_rd_addr), .rd_data(c_rd_data), .busy(c_busy), .done(c_done),
        .len_err(c_len_err), .overrun(c_overrun), .pix_count(c_pix_count),
        .checksum(c_checksum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic sc);
        start = 1'b1;
        scale = sc;
        step();
        start = 1'b0;
    endtask

    task automatic send(input logic [7:0] d, input logic last);
        pix_valid = 1'b1;
        pix_data  = d;
        pix_last  = last;
        step();
        pix_valid = 1'b0;
        pix_last  = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL rst_busy: got %0b want 0", busy); end
        tests_run++; if (done !== 1'b0) begin tests_failed++; $display("FAIL rst_done: got %0b want 0", done); end
        tests_run++; if (len_err !== 1'b0 || overrun !== 1'b0) begin tests_failed++; $display("FAIL rst_flags: got len_err=%0b overrun=%0b want 0 0", len_err, overrun); end
        tests_run++; if (pix_count !== 21'd0 || checksum !== 24'd0) begin tests_failed++; $display("FAIL rst_count: got count=%0d sum=%0d want 0 0", pix_count, checksum); end
        tests_run++; if (rd_data !== 8'd0) begin tests_failed++; $display("FAIL rst_rd_data: got %0d want 0", rd_data); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_downscale();
        int exp_dn[4];
        exp_dn = '{10, 20, 30, 40};
        do_start(1'b0);
        tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL dn_busy: got %0b want 1", busy); end
        send(8'd10, 1'b0);
        tests_run++; if (pix_count !== 21'd1 || checksum !== 24'd10) begin tests_failed++; $display("FAIL dn_first: got count=%0d sum=%0d want 1 10", pix_count, checksum); end
        send(8'd20, 1'b0);
        send(8'd30, 1'b0);
        send(8'd40, 1'b1);
        tests_run++; if (done !== 1'b1 || busy !== 1'b0) begin tests_failed++; $display("FAIL dn_done: got done=%0b busy=%0b want 1 0", done, busy); end
        tests_run++; if (len_err !== 1'b0 || overrun !== 1'b0) begin tests_failed++; $display("FAIL dn_flags: got len_err=%0b overrun=%0b want 0 0", len_err, overrun); end
        tests_run++; if (pix_count !== 21'd4) begin tests_failed++; $display("FAIL dn_count: got %0d want 4", pix_count); end
        tests_run++; if (checksum !== 24'd100) begin tests_failed++; $display("FAIL dn_sum: got %0d want 100", checksum); end
        for (int i = 0; i < 4; i++) begin
            rd_addr = 8'(i);
            step();
            tests_run++; if (rd_data !== 8'(exp_dn[i])) begin tests_failed++; $display("FAIL dn_read[%0d]: got %0d want %0d", i, rd_data, exp_dn[i]); end
        end
    endtask

    task automatic test_upscale_capacity();
        int a;
        do_start(1'b1);
        for (int i = 0; i < 144; i++) begin
            send(8'(i), (i == 143));
        end
        tests_run++; if (pix_count !== 21'd144) begin tests_failed++; $display("FAIL up_count: got %0d want 144", pix_count); end
        tests_run++; if (checksum !== 24'd10296) begin tests_failed++; $display("FAIL up_sum: got %0d want 10296", checksum); end
        tests_run++; if (len_err !== 1'b0 || overrun !== 1'b0 || done !== 1'b1) begin tests_failed++; $display("FAIL up_flags: got len_err=%0b overrun=%0b done=%0b want 0 0 1", len_err, overrun, done); end
        rd_addr = 8'd143;
        step();
        tests_run++; if (rd_data !== 8'd143) begin tests_failed++; $display("FAIL up_read143: got %0d want 143", rd_data); end
        tests_run++; if (c_overrun !== 1'b1) begin tests_failed++; $display("FAIL cap_overrun: got %0b want 1", c_overrun); end
        tests_run++; if (c_checksum !== 24'd10296 || c_pix_count !== 21'd144) begin tests_failed++; $display("FAIL cap_sum: got sum=%0d count=%0d want 10296 144", c_checksum, c_pix_count); end
        for (int i = 0; i < 4; i++) begin
            c_rd_addr = 2'(i);
            step();
            tests_run++; if (c_rd_data !== 8'(i)) begin tests_failed++; $display("FAIL cap_read[%0d]: got %0d want %0d", i, c_rd_data, i); end
        end
        a = 4;
        c_rd_addr = a[1:0];
        step();
        tests_run++; if (c_rd_data !== 8'd0) begin tests_failed++; $display("FAIL cap_read4: got %0d want 0", c_rd_data); end
    endtask

    task automatic test_short_long();
        do_start(1'b0);
        send(8'd5, 1'b0);
        send(8'd6, 1'b0);
        send(8'd7, 1'b1);
        tests_run++; if (len_err !== 1'b1 || overrun !== 1'b0) begin tests_failed++; $display("FAIL short_flags: got len_err=%0b overrun=%0b want 1 0", len_err, overrun); end
        tests_run++; if (pix_count !== 21'd3 || checksum !== 24'd18) begin tests_failed++; $display("FAIL short_count: got count=%0d sum=%0d want 3 18", pix_count, checksum); end
        do_start(1'b0);
        for (int i = 1; i <= 6; i++) begin
            send(8'(i), (i == 6));
        end
        tests_run++; if (len_err !== 1'b1 || overrun !== 1'b1) begin tests_failed++; $display("FAIL long_flags: got len_err=%0b overrun=%0b want 1 1", len_err, overrun); end
        tests_run++; if (pix_count !== 21'd6 || checksum !== 24'd21) begin tests_failed++; $display("FAIL long_count: got count=%0d sum=%0d want 6 21", pix_count, checksum); end
    endtask

    task automatic test_sticky_last();
        pix_last = 1'b1;
        pix_data = 8'd99;
        for (int i = 0; i < 6; i++) begin
            pix_valid = (i % 2 == 0);
            step();
        end
        pix_valid = 1'b0;
        tests_run++; if (pix_count !== 21'd6 || checksum !== 24'd21 || done !== 1'b1) begin tests_failed++; $display("FAIL sticky_hold: got count=%0d sum=%0d done=%0b want 6 21 1", pix_count, checksum, done); end
        start = 1'b1;
        scale = 1'b0;
        step();
        start = 1'b0;
        tests_run++; if (busy !== 1'b1 || pix_count !== 21'd0) begin tests_failed++; $display("FAIL sticky_restart: got busy=%0b count=%0d want 1 0", busy, pix_count); end
        pix_valid = 1'b1;
        pix_data  = 8'd7;
        step();
        pix_valid = 1'b0;
        pix_last  = 1'b0;
        tests_run++; if (done !== 1'b1 || pix_count !== 21'd1 || checksum !== 24'd7) begin tests_failed++; $display("FAIL sticky_close: got done=%0b count=%0d sum=%0d want 1 1 7", done, pix_count, checksum); end
    endtask

    task automatic test_restart();
        do_start(1'b0);
        send(8'd50, 1'b0);
        send(8'd60, 1'b0);
        do_start(1'b0);
        tests_run++; if (pix_count !== 21'd0 || checksum !== 24'd0 || busy !== 1'b1) begin tests_failed++; $display("FAIL restart: got count=%0d sum=%0d busy=%0b want 0 0 1", pix_count, checksum, busy); end
        pix_valid = 1'b1;
        pix_data  = 8'd33;
        start     = 1'b1;
        step();
        start     = 1'b0;
        pix_valid = 1'b0;
        tests_run++; if (pix_count !== 21'd0 || checksum !== 24'd0) begin tests_failed++; $display("FAIL start_priority: got count=%0d sum=%0d want 0 0", pix_count, checksum); end
    endtask

    task automatic test_async_reset();
        send(8'd11, 1'b0);
        send(8'd12, 1'b0);
        rd_addr = 8'd0;
        #2;
        rst_n = 1'b0;
        #1;
        tests_run++; if (busy !== 1'b0 || done !== 1'b0 || len_err !== 1'b0 || overrun !== 1'b0) begin tests_failed++; $display("FAIL areset_flags: got busy=%0b done=%0b len_err=%0b overrun=%0b want 0 0 0 0", busy, done, len_err, overrun); end
        tests_run++; if (pix_count !== 21'd0 || checksum !== 24'd0 || rd_data !== 8'd0) begin tests_failed++; $display("FAIL areset_data: got count=%0d sum=%0d rd=%0d want 0 0 0", pix_count, checksum, rd_data); end
        rst_n = 1'b1;
        pix_valid = 1'b1;
        pix_data  = 8'd9;
        step();
        pix_valid = 1'b0;
        tests_run++; if (busy !== 1'b0 || done !== 1'b0 || pix_count !== 21'd0) begin tests_failed++; $display("FAIL areset_idle: got busy=%0b done=%0b count=%0d want 0 0 0", busy, done, pix_count); end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        start        = 1'b0;
        scale        = 1'b0;
        pix_valid    = 1'b0;
        pix_data     = 8'd0;
        pix_last     = 1'b0;
        rd_addr      = 8'd0;
        c_rd_addr    = 2'd0;
        test_reset();
        test_downscale();
        test_upscale_capacity();
        test_short_long();
        test_sticky_last();
        test_restart();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
